// File: rtl/regfile_writeback_unit.sv
// Register-file write-port master: merges pipeline write-back with queued mul/div results.
// Optional queue bypass lookup is built only when WB_BYPASS_EN is defined.
module regfile_writeback_unit #(
   parameter int unsigned QDEPTH = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_reg,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              md_valid,
   input  logic [ADDR_W-1:0] md_reg,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   output logic [ADDR_W-1:0] Writereg,
   output logic [DATA_W-1:0] Writedata,
   output logic              RegWrite,
   output logic [2:0]        pending_cnt,
   input  logic [ADDR_W-1:0] byp_reg,
   output logic              byp_hit,
   output logic [DATA_W-1:0] byp_data
);

   localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [ADDR_W-1:0] r_q_reg  [QDEPTH];
   logic [DATA_W-1:0] r_q_data [QDEPTH];
   logic              r_q_vld  [QDEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [2:0]        r_cnt;

   logic              r_regwrite;
   logic [ADDR_W-1:0] r_writereg;
   logic [DATA_W-1:0] r_writedata;

   logic              w_md_ready;
   logic              w_md_acc;
   logic              w_pipe_issue;
   logic              w_q_nempty;
   logic              w_pop;
   logic              w_push;
   logic              w_md_direct;
   logic              w_issue;
   logic [ADDR_W-1:0] w_issue_reg;
   logic [DATA_W-1:0] w_issue_data;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(QDEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign w_md_ready   = !reset && (r_cnt < 3'(QDEPTH));
   assign w_md_acc     = md_valid && w_md_ready;
   assign w_pipe_issue = pipe_valid && (pipe_reg != '0);
   assign w_q_nempty   = (r_cnt != 3'd0);
   assign w_pop        = !w_pipe_issue && w_q_nempty;
   assign w_md_direct  = !w_pipe_issue && !w_q_nempty && w_md_acc && (md_reg != '0);

   // Register 0 and results shadowed by a same-cycle pipeline write are consumed and dropped.
   assign w_push = w_md_acc && !w_md_direct && (md_reg != '0)
                   && !(w_pipe_issue && (md_reg == pipe_reg));

   always_comb begin
      w_issue      = 1'b0;
      w_issue_reg  = pipe_reg;
      w_issue_data = pipe_data;
      if (w_pipe_issue) begin
         w_issue = 1'b1;
      end else if (w_q_nempty) begin
         // An invalidated head is popped silently.
         w_issue      = r_q_vld[r_head];
         w_issue_reg  = r_q_reg[r_head];
         w_issue_data = r_q_data[r_head];
      end else if (w_md_direct) begin
         w_issue      = 1'b1;
         w_issue_reg  = md_reg;
         w_issue_data = md_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_regwrite  <= 1'b0;
         r_writereg  <= '0;
         r_writedata <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_cnt       <= 3'd0;
         for (int i = 0; i < int'(QDEPTH); i++) begin
            r_q_vld[i] <= 1'b0;
         end
      end else begin
         r_regwrite <= w_issue;
         if (w_issue) begin
            r_writereg  <= w_issue_reg;
            r_writedata <= w_issue_data;
         end
         // Pipeline results are architecturally newer than anything still queued.
         if (w_pipe_issue) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
               if (r_q_reg[i] == pipe_reg) begin
                  r_q_vld[i] <= 1'b0;
               end
            end
         end
         if (w_push) begin
            r_q_reg[r_tail]  <= md_reg;
            r_q_data[r_tail] <= md_data;
            r_q_vld[r_tail]  <= 1'b1;
            r_tail           <= f_next(r_tail);
         end
         if (w_pop) begin
            r_head <= f_next(r_head);
         end
         r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      end
   end

`ifdef WB_BYPASS_EN
   logic              w_byp_hit;
   logic [DATA_W-1:0] w_byp_data;
   logic [PTR_W-1:0]  w_idx;

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      w_byp_hit  = 1'b0;
      w_byp_data = '0;
      w_idx      = r_head;
      for (int k = 0; k < int'(QDEPTH); k++) begin
         if ((k < int'(r_cnt)) && r_q_vld[w_idx] && (r_q_reg[w_idx] == byp_reg)
             && (byp_reg != '0)) begin
            w_byp_hit  = 1'b1;
            w_byp_data = r_q_data[w_idx];
         end
         w_idx = f_next(w_idx);
      end
   end

   assign byp_hit  = w_byp_hit;
   assign byp_data = w_byp_data;
`else
   logic w_unused_byp;

   assign w_unused_byp = ^byp_reg;
   assign byp_hit      = 1'b0;
   assign byp_data     = '0;
`endif

   assign md_ready    = w_md_ready;
   assign RegWrite    = r_regwrite;
   assign Writereg    = r_writereg;
   assign Writedata   = r_writedata;
   assign pending_cnt = r_cnt;

endmodule
